// File: rtl/pwm_multi.sv
// Multi-channel complementary PWM with a shared sawtooth/center counter,
// per-channel dead time and period-boundary shadow reload.
module pwm_multi #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 16,
  parameter int DT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_W-1:0]      period,
  input  logic [N_CH*CNT_W-1:0] duty,
  input  logic [DT_W-1:0]       dead_time,
  input  logic                  mode,
  input  logic                  pwm_enable,
  input  logic                  ovf_trigger_enable,
  output logic [N_CH-1:0]       pwm,
  output logic [N_CH-1:0]       pwm_cmp,
  output logic                  ovf_trigger,
  output logic [CNT_W-1:0]      counter_dbg
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_nx;
  logic                        dir_dn;
  logic                        dir_nx;
  logic                        wrap;
  logic                        reload;
  logic                        out_en;
  logic [CNT_W-1:0]            per_s;
  logic [N_CH-1:0][CNT_W-1:0]  duty_s;
  logic [DT_W-1:0]             dt_s;
  logic                        mode_s;
  logic [N_CH-1:0]             ref_v;
  logic                        ovf_q;

  // Next counter value, direction and the wrap/valley event.
  // A zero period parks the counter but keeps the shadows
  // transparent so a new period can still be loaded.
  always_comb begin
    wrap   = 1'b0;
    reload = 1'b0;
    cnt_nx = cnt;
    dir_nx = dir_dn;
    if (per_s == '0) begin
      reload = 1'b1;
      cnt_nx = '0;
      dir_nx = 1'b0;
    end else if (!mode_s) begin
      dir_nx = 1'b0;
      if (cnt >= per_s - ONE) begin
        wrap   = 1'b1;
        cnt_nx = '0;
      end else begin
        cnt_nx = cnt + ONE;
      end
    end else if (cnt == ONE && (dir_dn || per_s == ONE)) begin
      wrap   = 1'b1;
      cnt_nx = '0;
      dir_nx = 1'b0;
    end else if (!dir_dn && cnt >= per_s) begin
      cnt_nx = cnt - ONE;
      dir_nx = 1'b1;
    end else if (!dir_dn) begin
      cnt_nx = cnt + ONE;
    end else begin
      cnt_nx = cnt - ONE;
    end
    if (wrap) reload = 1'b1;
  end

  // Shared period counter and direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      dir_dn <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      dir_dn <= dir_nx;
    end
  end

  // Shadow registers: transparent in reset, else updated at wrap.
  always_ff @(posedge clk) begin
    if (reset || reload) begin
      per_s  <= period;
      duty_s <= duty;
      dt_s   <= dead_time;
      mode_s <= mode;
    end
  end

  // Overflow pulse lands with the counter-0 cycle after a wrap.
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= wrap & ovf_trigger_enable;
  end

  // Per-channel compare reference.
  always_comb begin
    ref_v = '0;
    for (int i = 0; i < N_CH; i++)
      ref_v[i] = (cnt < duty_s[i]);
  end

  assign out_en = pwm_enable && (per_s != '0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DT_W-1:0] hcnt;
    logic [DT_W-1:0] lcnt;
    logic            p_q;
    logic            c_q;

    // Count consecutive cycles of each ref level; a side rises only
    // once its level has persisted past the dead time.
    always_ff @(posedge clk) begin
      if (reset || !out_en) begin
        hcnt <= '0;
        lcnt <= '0;
        p_q  <= 1'b0;
        c_q  <= 1'b0;
      end else if (ref_v[i]) begin
        lcnt <= '0;
        c_q  <= 1'b0;
        p_q  <= (hcnt >= dt_s);
        if (hcnt != '1) hcnt <= hcnt + DT_W'(1);
      end else begin
        hcnt <= '0;
        p_q  <= 1'b0;
        c_q  <= (lcnt >= dt_s);
        if (lcnt != '1) lcnt <= lcnt + DT_W'(1);
      end
    end

    assign pwm[i]     = p_q;
    assign pwm_cmp[i] = c_q;
  end

  assign ovf_trigger = ovf_q;
  assign counter_dbg = cnt;

endmodule
